password_fsm: RTL



---
 rtl/password_fsm.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/password_fsm.sv
// Four-digit code entry sequencer driving the HEX display state bus.
// Optional lockout after MAX_FAILS failures: define PASSWORD_LOCKOUT_EN.
module password_fsm #(
    parameter logic [15:0] PASSWORD  = 16'h1234,
    parameter int unsigned ERR_HOLD  = 50_000_000,
    parameter int unsigned MAX_FAILS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit,
    input  logic       enter,
    input  logic       clear,
    output logic [2:0] state,
    output logic [1:0] fails,
    output logic       locked
);

    localparam int unsigned   TW        = (ERR_HOLD > 1) ? $clog2(ERR_HOLD) : 1;
    localparam logic [TW-1:0] HOLD_LAST = TW'(ERR_HOLD - 1);
    localparam logic [1:0]    FAIL_MAX  = 2'(MAX_FAILS);

    typedef enum logic [2:0] {
        IDLE     = 3'b000,
        D1       = 3'b001,
        D2       = 3'b010,
        D3       = 3'b011,
        CHECK    = 3'b100,
        ERROR    = 3'b101,
        COMPLETE = 3'b110
    } state_e;

    state_e        state_q, state_d;
    logic          mismatch_q, mismatch_d;
    logic          enter_q;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    fails_q, fails_d;
    logic [1:0]    fail_next;
    logic [3:0]    exp_nib;
    logic          enter_p;
    logic          hold_lock;

`ifdef PASSWORD_LOCKOUT_EN
    logic locked_q, locked_d;
    assign hold_lock = locked_q;
    assign locked    = locked_q;
`else
    assign hold_lock = 1'b0;
    assign locked    = 1'b0;
`endif

    assign enter_p   = enter & ~enter_q;
    assign fail_next = (fails_q >= FAIL_MAX) ? FAIL_MAX : fails_q + 2'd1;

    always_comb begin
        case (state_q)
            IDLE:    exp_nib = PASSWORD[15:12];
            D1:      exp_nib = PASSWORD[11:8];
            D2:      exp_nib = PASSWORD[7:4];
            default: exp_nib = PASSWORD[3:0];
        endcase
    end

    always_comb begin
        state_d    = state_q;
        mismatch_d = mismatch_q;
        timer_d    = timer_q;
        fails_d    = fails_q;
`ifdef PASSWORD_LOCKOUT_EN
        locked_d   = locked_q;
`endif
        case (state_q)
            IDLE, D1, D2, D3: begin
                if (clear) begin
                    state_d    = IDLE;
                    mismatch_d = 1'b0;
                    timer_d    = '0;
                end else if (enter_p) begin
                    // First digit restarts the sticky compare
                    mismatch_d = ((state_q == IDLE) ? 1'b0 : mismatch_q)
                               | (digit != exp_nib);
                    state_d    = (state_q == D3) ? CHECK
                                                 : state_e'(state_q + 3'd1);
                end
            end
            CHECK: begin
                if (!mismatch_q) begin
                    state_d = COMPLETE;
                    fails_d = 2'd0;
                end else begin
                    state_d = ERROR;
                    fails_d = fail_next;
                    timer_d = '0;
`ifdef PASSWORD_LOCKOUT_EN
                    locked_d = (fail_next == FAIL_MAX);
`endif
                end
            end
            ERROR: begin
                if (!hold_lock) begin
                    if (clear || timer_q == HOLD_LAST) begin
                        state_d    = IDLE;
                        mismatch_d = 1'b0;
                        timer_d    = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            COMPLETE: begin
                if (clear) begin
                    state_d    = IDLE;
                    mismatch_d = 1'b0;
                    timer_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mismatch_q <= 1'b0;
            enter_q    <= 1'b0;
            timer_q    <= '0;
            fails_q    <= 2'd0;
`ifdef PASSWORD_LOCKOUT_EN
            locked_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            mismatch_q <= mismatch_d;
            enter_q    <= enter;
            timer_q    <= timer_d;
            fails_q    <= fails_d;
`ifdef PASSWORD_LOCKOUT_EN
            locked_q   <= locked_d;
`endif
        end
    end

    assign state = state_q;
    assign fails = fails_q;

endmodule
